// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MD op, PC select encodings and exception vector for the pipeline
package pipe_pkg;
  typedef enum logic [1:0] {MD_NONE = 2'd0, MD_MULT = 2'd1, MD_DIV = 2'd2} md_op_t;
  typedef enum logic [1:0] {PC_NEXT = 2'd0, PC_EXC = 2'd1, PC_EPC = 2'd2} pc_sel_t;
  localparam logic [31:0] EXC_VECTOR = 32'h00004180;
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: loadable multiply/divide occupancy down-counter
module md_busy_timer import pipe_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  localparam int W = $clog2(DIV_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] start,
  output logic       busy
);
  logic [W-1:0] md_cnt;
  assign busy = md_cnt != '0;
  always_ff @(posedge clk)
    if (!reset) md_cnt <= '0;
    else md_cnt <= start == MD_MULT ? W'(MULT_CYCLES) :
                   start == MD_DIV  ? W'(DIV_CYCLES)  : md_cnt - W'(busy);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer; `PIPE_CTRL_STALL_CNT_EN adds a saturating stall counter
module pipe_ctrl import pipe_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_data_stall,
  input  logic        d_is_md,
  input  logic [1:0]  e_md_start,
  input  logic        d_eret,
  input  logic        exc_req,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        fd_halt,
  output logic        fd_clr,
  output logic        de_clr,
  output logic        stage_req,
`ifdef PIPE_CTRL_STALL_CNT_EN
  output logic        md_busy,
  output logic [31:0] stall_cnt
`else
  output logic        md_busy
`endif
);
  logic stall;
  logic [1:0] md_start_eff;
  // a start flushed by an exception never reaches the MD unit
  assign md_start_eff = exc_req ? 2'(MD_NONE) : e_md_start;
  md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(md_start_eff),
    .busy(md_busy)
  );
  always_comb begin
    stall = d_data_stall | (d_is_md & (md_busy | e_md_start != MD_NONE));
    stage_req = exc_req;
    pc_en = exc_req | ~stall;
    pc_sel = exc_req ? 2'(PC_EXC) : (!stall && d_eret) ? 2'(PC_EPC) : 2'(PC_NEXT);
    fd_halt = ~exc_req & stall;
    de_clr = ~exc_req & stall;
    fd_clr = ~exc_req & ~stall & d_eret;
  end
`ifdef PIPE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk)
    if (!reset) stall_cnt <= '0;
    else stall_cnt <= stall_cnt + 32'(stall & ~exc_req & ~&stall_cnt);
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven decode vectors plus multi-cycle MD counter sequences
module tb_pipe_ctrl;
  import pipe_pkg::*;
  logic clk = 0, reset = 0, d_data_stall = 0, d_is_md = 0, d_eret = 0, exc_req = 0;
  logic [1:0] e_md_start = 0;
  logic pc_en, fd_halt, fd_clr, de_clr, stage_req, md_busy;
  logic [1:0] pc_sel;
  logic [31:0] stall_cnt;
  logic [7:0] outs;
  int total = 0, bad = 0;
  localparam logic [7:0] O_NRM = 8'b1000_0000;
  localparam logic [7:0] O_STL = 8'b0001_0100;
  localparam logic [7:0] O_ERT = 8'b1100_1000;
  localparam logic [7:0] O_EXC = 8'b1010_0010;
  typedef struct {
    string name;
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[11];
  pipe_ctrl dut (
    .clk(clk), .reset(reset), .d_data_stall(d_data_stall), .d_is_md(d_is_md),
    .e_md_start(e_md_start), .d_eret(d_eret), .exc_req(exc_req), .pc_en(pc_en),
    .pc_sel(pc_sel), .fd_halt(fd_halt), .fd_clr(fd_clr), .de_clr(de_clr),
    .stage_req(stage_req),
`ifdef PIPE_CTRL_STALL_CNT_EN
    .md_busy(md_busy), .stall_cnt(stall_cnt)
`else
    .md_busy(md_busy)
`endif
  );
`ifndef PIPE_CTRL_STALL_CNT_EN
  assign stall_cnt = '0;
`endif
  assign outs = {pc_en, pc_sel, fd_halt, fd_clr, de_clr, stage_req, md_busy};
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic [5:0] v);
    {d_data_stall, d_is_md, e_md_start, d_eret, exc_req} = v;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic chk_o(input string n, input logic [7:0] exp);
    @(negedge clk);
    chk(n, 32'(outs), 32'(exp));
  endtask
  initial begin
    tv[0]  = '{"idle",          6'b0_0_00_0_0, O_NRM};
    tv[1]  = '{"data_stall",    6'b1_0_00_0_0, O_STL};
    tv[2]  = '{"md_no_busy",    6'b0_1_00_0_0, O_NRM};
    tv[3]  = '{"md_vs_mult",    6'b0_1_01_0_0, O_STL};
    tv[4]  = '{"div_no_dep",    6'b0_0_10_0_0, O_NRM};
    tv[5]  = '{"eret",          6'b0_0_00_1_0, O_ERT};
    tv[6]  = '{"eret_stall",    6'b1_0_00_1_0, O_STL};
    tv[7]  = '{"exc",           6'b0_0_00_0_1, O_EXC};
    tv[8]  = '{"exc_all",       6'b1_0_00_1_1, O_EXC};
    tv[9]  = '{"exc_md_div",    6'b0_1_10_0_1, O_EXC};
    tv[10] = '{"eret_md_mult",  6'b0_1_01_1_0, O_STL};
    cyc;
    cyc;
    // reset held low so table vectors never leave the counter loaded
    foreach (tv[i]) begin
      set_in(tv[i].in);
      chk_o(tv[i].name, tv[i].exp);
      cyc;
    end
    set_in(0);
    reset = 1;
    chk_o("reset_state", O_NRM);
    cyc;
    for (int c = 0; c <= 6; c++) begin
      set_in({1'b0, 1'b1, (c == 0) ? 2'(MD_MULT) : 2'(MD_NONE), 2'b00});
      chk_o($sformatf("mult_dep_c%0d", c), c == 0 ? O_STL : c <= 5 ? (O_STL | 8'd1) : O_NRM);
      cyc;
    end
    for (int c = 0; c <= 11; c++) begin
      set_in({2'b00, (c == 0) ? 2'(MD_DIV) : 2'(MD_NONE), 2'b00});
      chk_o($sformatf("div_nodep_c%0d", c), (c >= 1 && c <= 10) ? (O_NRM | 8'd1) : O_NRM);
      cyc;
    end
    set_in(6'b0_0_10_0_1);
    chk_o("exc_flush_div", O_EXC);
    cyc;
    set_in(0);
    chk_o("exc_flush_div_next", O_NRM);
    cyc;
    set_in(6'b0_0_01_0_0);
    chk_o("mult_then_exc_c0", O_NRM);
    cyc;
    set_in(6'b0_0_00_0_1);
    chk_o("mult_then_exc_c1", O_EXC | 8'd1);
    cyc;
    set_in(0);
    chk_o("mult_then_exc_c2", O_NRM | 8'd1);
    repeat (4) cyc;
    chk_o("mult_then_exc_c6", O_NRM);
    cyc;
    set_in(6'b1_0_00_1_0);
    chk_o("eret_stalled", O_STL);
    cyc;
    set_in(6'b0_0_00_1_0);
    chk_o("eret_released", O_ERT);
    cyc;
    set_in(6'b0_0_10_0_0);
    chk_o("div_reset_c0", O_NRM);
    cyc;
    set_in(0);
    repeat (6) cyc;
    chk_o("div_reset_c7_cnt4", O_NRM | 8'd1);
    reset = 0;
    cyc;
    reset = 1;
    chk_o("div_reset_c8", O_NRM);
    cyc;
    chk_o("div_reset_c9", O_NRM);
`ifdef PIPE_CTRL_STALL_CNT_EN
    reset = 0;
    cyc;
    reset = 1;
    @(negedge clk);
    chk("stall_cnt_reset", stall_cnt, 32'd0);
    cyc;
    for (int c = 0; c <= 5; c++) begin
      set_in({1'b0, 1'b1, (c == 0) ? 2'(MD_MULT) : 2'(MD_NONE), 2'b00});
      cyc;
    end
    set_in(6'b1_0_00_0_0);
    cyc;
    set_in(6'b1_0_00_0_1);
    @(negedge clk);
    chk("stall_cnt_7", stall_cnt, 32'd7);
    cyc;
    set_in(0);
    @(negedge clk);
    chk("stall_cnt_exc_ignored", stall_cnt, 32'd7);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It turns hazard, multiply/divide-busy, exception and `eret` conditions into per-stage hold and clear controls for the F/D, D/E, E/M and M/W stage registers, and a next-PC select for the fetch stage. It owns the only sequential timer in the control path: the multiply/divide occupancy counter.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a `mult`/`multu` issue.
- `DIV_CYCLES`, default 10: busy cycles after a `div`/`divu` issue.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; state clears on a posedge where `reset`==0.
- `d_data_stall`  in  1  operand hazard from D-stage Tuse/Tnew compare.
- `d_is_md`  in  1  D instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo).
- `e_md_start`  in  2  E-stage MD issue: `MD_NONE`, `MD_MULT`, `MD_DIV`.
- `d_eret`  in  1  D instruction is `eret`.
- `exc_req`  in  1  interrupt/exception taken, from CP0 in M.
- `pc_en`  out  1  PC register update enable.
- `pc_sel`  out  2  `PC_NEXT`, `PC_EXC` (0x00004180), `PC_EPC`.
- `fd_halt`, `fd_clr`  out  1 each  F/D hold / clear.
- `de_clr`  out  1  D/E clear (bubble insert).
- `stage_req`  out  1  exception flush to all four stage registers.
- `md_busy`  out  1  MD unit occupied.

## Operation
- All outputs except `md_busy` are combinational from the inputs and `md_busy`. Only `md_cnt` (width `$clog2(DIV_CYCLES+1)`) and the optional counter are registered.
- Counter:
  - an effective `e_md_start` of `MD_MULT` loads `MULT_CYCLES`; `MD_DIV` loads `DIV_CYCLES`;
  - otherwise the counter decrements when nonzero and holds at 0;
  - `md_busy` = (`md_cnt` != 0).
- An `e_md_start` is effective only when `exc_req`==0. A start coinciding with an exception is flushed and does not load the counter.
- An exception while the counter is busy does not abort it. The operation is already committed.
- `md_stall` = `d_is_md` & (`md_busy` | `e_md_start` != `MD_NONE`).
- `stall` = `d_data_stall` | `md_stall`.
- Priority is exception > stall > eret > normal:
  - Exception: `stage_req`=1, `pc_en`=1, `pc_sel`=`PC_EXC`, `fd_halt`=0, `fd_clr`=0, `de_clr`=0. The stage registers handle the request themselves.
  - Stall: `pc_en`=0, `fd_halt`=1, `de_clr`=1, `fd_clr`=0.
  - Eret: `pc_en`=1, `pc_sel`=`PC_EPC`, `fd_clr`=1 (squash the wrong-path fetch; there is no delay slot after `eret`).
  - Normal: `pc_en`=1, `pc_sel`=`PC_NEXT`, all hold/clear outputs 0.
- An `e_md_start` arriving while `md_busy`=1 cannot occur legally, because D stalls. If it does occur, the counter reloads.

## Timing
- Reset values: `md_cnt`=0, so `md_busy`=0. With all inputs low: `pc_en`=1, `pc_sel`=`PC_NEXT`, all other outputs 0.
- An MD start in cycle t gives `md_busy`=1 during cycles t+1 … t+N (N = `MULT_CYCLES` or `DIV_CYCLES`) and 0 in cycle t+N+1.
- A dependent MD instruction in D therefore stalls N+1 cycles in total. Stall in cycle t comes from `e_md_start`; stall in cycles t+1 … t+N comes from `md_busy`.
- If `reset`==0 mid-count, `md_cnt` is cleared at that edge.

## Configuration
- `PIPE_CTRL_STALL_CNT_EN` defined:
  - adds output `stall_cnt` (32 bits), reset to 0;
  - increments on every cycle with `stall`=1 and `exc_req`=0;
  - saturates at 0xFFFFFFFF.
- `PIPE_CTRL_STALL_CNT_EN` undefined: the port and the register are absent. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - `md_op_t` with values `MD_NONE`=0, `MD_MULT`=1, `MD_DIV`=2;
  - `pc_sel_t` with values `PC_NEXT`=0, `PC_EXC`=1, `PC_EPC`=2;
  - constant `EXC_VECTOR` = 32'h00004180, shared with the stage registers.
- One sub-module, `md_busy_timer`: the loadable down-counter with the `busy` output. Priority decode stays in `pipe_ctrl`.

## Test plan
- Reset, then `e_md_start`=`MD_MULT` at t=0 with `d_is_md`=1 held → `fd_halt`=1 and `de_clr`=1 for cycles 0–5, 0 at cycle 6; `md_busy` is high in cycles 1–5.
- `MD_DIV` start, then `d_is_md`=0 → no stall; `md_busy` is high for exactly 10 cycles.
- `exc_req`=1 together with `e_md_start`=`MD_DIV` → `stage_req`=1, `pc_sel`=1, `pc_en`=1, and `md_busy` stays 0 the next cycle.
- `d_eret`=1 with `d_data_stall`=1 → stall outputs, `pc_en`=0, `fd_clr`=0. Next cycle, stall drops → `pc_sel`=2, `fd_clr`=1.
- `reset`=0 asserted at `md_cnt`=4 during a div → `md_busy`=0 the following cycle; outputs return to reset values.
- With `PIPE_CTRL_STALL_CNT_EN`: a 6-cycle mult stall followed by one `d_data_stall` cycle → `stall_cnt`=7.
